// File: rtl/timer_dev.sv
// timer_dev: memory-mapped programmable countdown timer.
// Three word registers (CTRL, PRESET, COUNT) behind a 2-bit word address.
// CTRL = {IM, MODE[1:0], EN}. MODE=1 auto-reloads; every other MODE is one-shot.
// irq is registered and always equals irq_flag & CTRL.IM.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | stopped; COUNT held; leaves when EN=1
// LOAD  | one cycle: COUNT <= PRESET, prescaler cleared
// CNT   | counting; COUNT decrements on each prescaler tick
// INT   | one cycle after expiry: one-shot clears EN, auto-reload reloads
module timer_dev #(
  parameter int PRESCALE = 1,
  parameter int PSC_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [1:0]       ADDR_CTRL   = 2'd0;
  localparam logic [1:0]       ADDR_PRESET = 2'd1;
  localparam logic [1:0]       ADDR_COUNT  = 2'd2;
  localparam logic [PSC_W-1:0] PSC_LAST    = PSC_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [3:0]       ctrl, ctrl_n;
  logic [31:0]      preset, preset_n;
  logic [31:0]      count, count_n;
  logic [PSC_W-1:0] psc, psc_n;
  logic             irq_flag, irq_flag_n;

  logic ctrl_wr;
  logic preset_wr;
  logic tick;
  logic reload;

  assign ctrl_wr   = we && (addr == ADDR_CTRL);
  assign preset_wr = we && (addr == ADDR_PRESET);
  assign tick      = (psc == PSC_LAST);
  assign reload    = (ctrl[2:1] == 2'b01);

  // Next-state logic; a CTRL write overrides whatever the FSM would have done.
  always_comb begin
    state_n    = state;
    ctrl_n     = ctrl;
    preset_n   = preset;
    count_n    = count;
    psc_n      = psc;
    irq_flag_n = irq_flag;

    case (state)
      ST_IDLE: begin
        if (ctrl[0]) state_n = ST_LOAD;
      end
      ST_LOAD: begin
        // Uses the PRESET value from before this edge, even if it is being written now.
        count_n = preset;
        psc_n   = '0;
        state_n = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl[0]) begin
          state_n = ST_IDLE;
        end else begin
          psc_n = tick ? '0 : psc + PSC_W'(1);
          if (tick) begin
            if (count > 32'd1) begin
              count_n = count - 32'd1;
            end else begin
              // PRESET of 0 or 1 both land here on the first tick.
              count_n    = 32'd0;
              irq_flag_n = 1'b1;
              state_n    = ST_INT;
            end
          end
        end
      end
      ST_INT: begin
        if (reload) begin
          irq_flag_n = 1'b0;
          state_n    = ST_LOAD;
        end else begin
          ctrl_n[0] = 1'b0;
          state_n   = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (preset_wr) preset_n = wdata;

    if (ctrl_wr) begin
      ctrl_n     = wdata[3:0];
      irq_flag_n = 1'b0;
      state_n    = ST_IDLE;
      count_n    = count;
      psc_n      = psc;
    end
  end

  // State and register update; irq tracks the flag and mask on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      psc      <= '0;
      irq_flag <= 1'b0;
      irq      <= 1'b0;
    end else begin
      state    <= state_n;
      ctrl     <= ctrl_n;
      preset   <= preset_n;
      count    <= count_n;
      psc      <= psc_n;
      irq_flag <= irq_flag_n;
      irq      <= irq_flag_n & ctrl_n[3];
    end
  end

  // Combinational read mux; the reserved offset reads zero.
  always_comb begin
    rdata = 32'd0;
    case (addr)
      ADDR_CTRL:   rdata = {28'd0, ctrl};
      ADDR_PRESET: rdata = preset;
      ADDR_COUNT:  rdata = count;
      default:     rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: two timers (PRESCALE 1 and 4) share one bus; a time-anchored
// reference model predicts every register and irq each cycle.
module tb_timer_dev;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata0, rdata1;
  logic        irq0, irq1;

  always #5 clk = ~clk;

  timer_dev #(.PRESCALE(1), .PSC_W(8)) dut0 (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .wdata(wdata),
    .rdata(rdata0), .irq(irq0)
  );

  timer_dev #(.PRESCALE(4), .PSC_W(8)) dut1 (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .wdata(wdata),
    .rdata(rdata1), .irq(irq1)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: a countdown started (or reloaded) at edge A loads PRESET at A+2,
  // then loses one count every ps edges; it expires after max(PRESET,1) ticks.
  int          ps[2] = '{1, 4};
  logic [3:0]  m_ctrl[2];
  logic [31:0] m_preset[2];
  logic [31:0] m_count[2];
  logic [31:0] m_loaded[2];
  longint      m_len[2];
  bit          m_flag[2];
  bit          m_active[2];
  bit          m_pend[2];
  int          m_anchor[2];
  longint      k, ticks;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] m_rd(input int i, input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_ctrl[i]};
      2'd1:    return m_preset[i];
      2'd2:    return m_count[i];
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_ctrl[i] = 4'd0; m_preset[i] = 32'd0; m_count[i] = 32'd0; m_loaded[i] = 32'd0;
        m_len[i] = 1; m_flag[i] = 1'b0; m_active[i] = 1'b0; m_pend[i] = 1'b0; m_anchor[i] = 0;
      end else if (we && addr == 2'd0) begin
        m_ctrl[i]   = wdata[3:0];
        m_flag[i]   = 1'b0;
        m_pend[i]   = 1'b0;
        m_active[i] = wdata[0];
        m_anchor[i] = cyc;
      end else begin
        if (m_pend[i]) begin
          m_ctrl[i][0] = 1'b0;
          m_pend[i]    = 1'b0;
        end
        if (m_active[i]) begin
          k = longint'(cyc - m_anchor[i]);
          if (k == 1) begin
            m_flag[i] = 1'b0;
          end else if (k == 2) begin
            m_loaded[i] = m_preset[i];
            m_count[i]  = m_preset[i];
            m_len[i]    = (m_preset[i] == 0) ? 1 : longint'(m_preset[i]);
          end else if (k > 2) begin
            ticks = (k - 2) / ps[i];
            if (ticks >= m_len[i]) begin
              m_count[i] = 32'd0;
              m_flag[i]  = 1'b1;
              if (m_ctrl[i][2:1] == 2'b01) begin
                m_anchor[i] = cyc;
              end else begin
                m_active[i] = 1'b0;
                m_pend[i]   = 1'b1;
              end
            end else begin
              m_count[i] = m_loaded[i] - 32'(ticks);
            end
          end
        end
        if (we && addr == 2'd1) m_preset[i] = wdata;
      end
    end
  end

  // Every-cycle comparison against the model, just after the edge settles.
  always @(posedge clk) begin
    #1;
    chk("dut0_rdata", rdata0, m_rd(0, addr));
    chk("dut0_irq", {31'd0, irq0}, {31'd0, m_flag[0] & m_ctrl[0][3]});
    chk("dut1_rdata", rdata1, m_rd(1, addr));
    chk("dut1_irq", {31'd0, irq1}, {31'd0, m_flag[1] & m_ctrl[1][3]});
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, hi, wide;
    bit prev;
    logic [31:0] cexp[5];

    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset values at every offset.
    for (int a = 0; a < 4; a++) begin
      @(negedge clk); addr = 2'(a);
      settle();
      chk("reset_rd0", rdata0, 32'd0);
      chk("reset_rd1", rdata1, 32'd0);
      chk("reset_irq", {31'd0, irq0}, 32'd0);
    end

    // One-shot, PRESET=3: COUNT 3,2,1,0 and irq on the 5th edge.
    cexp = '{32'd0, 32'd3, 32'd2, 32'd1, 32'd0};
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    addr = 2'd2;
    for (int j = 0; j < 5; j++) begin
      settle();
      chk("t2_count", rdata0, cexp[j]);
      if (j == 3) chk("t2_irq_early", {31'd0, irq0}, 32'd0);
    end
    chk("t2_irq_rise", {31'd0, irq0}, 32'd1);
    @(negedge clk); addr = 2'd0;
    settle();
    chk("t2_ctrl_after", rdata0, 32'h8);
    chk("t2_irq_hold", {31'd0, irq0}, 32'd1);
    wr(2'd0, 32'h8);
    chk("t2_irq_clear", {31'd0, irq0}, 32'd0);

    // Auto-reload, PRESET=2: one-cycle pulse every 4 cycles.
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    hi = 0; wide = 0; prev = 1'b0;
    for (int j = 0; j < 12; j++) begin
      settle();
      if (irq0) hi++;
      if (irq0 && prev) wide++;
      prev = irq0;
    end
    chk("t3_pulses", 32'(hi), 32'd3);
    chk("t3_wide", 32'(wide), 32'd0);
    wr(2'd0, 32'h0);

    // PRESET rewritten during LOAD does not disturb the running countdown.
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    e0 = cyc;
    wr(2'd1, 32'd100);
    for (int j = 0; j < 50 && !irq0; j++) settle();
    chk("t4_lat5", 32'(cyc - e0), 32'd7);
    wr(2'd0, 32'h9);
    e0 = cyc;
    for (int j = 0; j < 200 && !irq0; j++) settle();
    chk("t4_lat100", 32'(cyc - e0), 32'd102);

    // CTRL write on the expiry edge wins.
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    repeat (3) @(negedge clk);
    wr(2'd0, 32'h8);
    addr = 2'd2;
    settle();
    chk("t5_irq_lost", {31'd0, irq0}, 32'd0);
    chk("t5_count_held", rdata0, 32'd1);
    repeat (3) settle();
    chk("t5_idle", rdata0, 32'd1);

    // Clearing EN mid-count freezes COUNT.
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    repeat (4) @(negedge clk);
    wr(2'd0, 32'h8);
    addr = 2'd2;
    settle();
    chk("t5_freeze", rdata0, 32'd7);
    repeat (4) settle();
    chk("t5_freeze_late", rdata0, 32'd7);

    // Prescaler of 4, PRESET=2: decrement every 4 cycles, irq after 10 edges.
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    e0 = cyc;
    addr = 2'd2;
    for (int j = 0; j < 40 && !irq1; j++) begin
      settle();
      if (cyc - e0 == 5) chk("t6_cnt_e5", rdata1, 32'd2);
      if (cyc - e0 == 6) chk("t6_cnt_e6", rdata1, 32'd1);
    end
    chk("t6_lat", 32'(cyc - e0), 32'd10);

    // Reset mid-count clears everything.
    wr(2'd1, 32'd50);
    wr(2'd0, 32'h9);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      @(negedge clk); addr = 2'(a);
      settle();
      chk("t6_rst_rd1", rdata1, 32'd0);
      chk("t6_rst_rd0", rdata0, 32'd0);
    end
    chk("t6_rst_irq", {31'd0, irq1}, 32'd0);

    // Random traffic, checked every cycle by the compare process.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      we    = ($urandom_range(0, 5) == 0);
      addr  = 2'($urandom_range(0, 3));
      case (addr)
        2'd0:    wdata = {28'd0, 4'($urandom_range(0, 15))} | (($urandom_range(0, 3) != 0) ? 32'd1 : 32'd0);
        2'd1:    wdata = 32'($urandom_range(0, 6));
        default: wdata = $urandom;
      endcase
    end
    @(negedge clk);
    reset = 1'b0; we = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
